// File: rtl/rv32m_pkg.sv
// Shared types and constants for the RV32M sequencing controller and its iterative core.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package rv32m_pkg;

    localparam int XLEN  = 32;
    localparam int STEPS = 32;
    localparam int CNT_W = $clog2(STEPS);

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [XLEN-1:0] INT_MIN       = 32'h8000_0000;

    // Operation kind carried through the pipeline and stored in the cache
    localparam logic KIND_MUL = 1'b0;
    localparam logic KIND_DIV = 1'b1;

    // Controller states
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_PREP = 3'd1;
    localparam state_t ST_CALC = 3'd2;
    localparam state_t ST_FIX  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // One cached result: the key fields plus a 64-bit word that is either the
    // signed-corrected product or {remainder, quotient}
    typedef struct packed {
        logic              kind;
        logic [XLEN-1:0]   rs1;
        logic [XLEN-1:0]   rs2;
        logic              signed_a;
        logic              signed_b;
        logic [2*XLEN-1:0] data;
    } cache_ent_t;

    // High half holds the MULH*/REM word, low half the MUL/DIV word
    function automatic logic [XLEN-1:0] sel_word(input logic [2*XLEN-1:0] w, input logic upper);
        return upper ? w[2*XLEN-1:XLEN] : w[XLEN-1:0];
    endfunction

endpackage

// File: rtl/rv32m_iter_core.sv
// Shared 64-bit iterative engine: shift-add multiplier or restoring divider, one step per enable.
// Latency: 32 step enables after load produce {hi,lo} = product or {remainder, quotient}.
// Backpressure: none; the controller decides when to load and step.
module rv32m_iter_core
    import rv32m_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic            step_i,
    input  logic            div_mode_i,
    input  logic [XLEN-1:0] op_i,
    input  logic [XLEN-1:0] init_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN-1:0] op_q;
    logic [XLEN-1:0] hi_q;
    logic [XLEN-1:0] lo_q;
    logic [XLEN-1:0] hi_d;
    logic [XLEN-1:0] lo_d;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;
    logic            unused_bits;

    // Multiply: add multiplicand into the upper half when the current multiplier bit is set
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, op_q} : {(XLEN+1){1'b0}});
    // Divide: shift the partial remainder left by one and trial-subtract the divisor
    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, op_q};
    // The trial difference never exceeds XLEN bits when it is kept, so its bit XLEN is don't-care
    assign unused_bits = ^{div_diff[XLEN], div_shift[XLEN]};

    assign hi_o = hi_q;
    assign lo_o = lo_q;

    // Next value of the 64-bit shift register for one step in the selected mode
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_mode_i) begin
            if (!div_diff[XLEN+1]) begin
                hi_d = div_diff[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                hi_d = div_shift[XLEN-1:0];
                lo_d = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            hi_d = mul_sum[XLEN:1];
            lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end
    end

    // Load operands or advance by one step
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            op_q <= '0;
            hi_q <= '0;
            lo_q <= '0;
        end else if (load_i) begin
            op_q <= op_i;
            hi_q <= '0;
            lo_q <= init_i;
        end else if (step_i) begin
            hi_q <= hi_d;
            lo_q <= lo_d;
        end
    end

endmodule

// File: rtl/rv32m_seq_ctrl.sv
// RV32M sequencer: one mul/div/rem at a time over a shared 32-step core; optional result cache (RV32M_OP_CACHE_EN).
// Latency: 35 cycles accept-to-valid, 2 for divide-by-zero/overflow, 1 on a cache hit.
// Backpressure: req_ready_o only in IDLE; result and tag held in DONE until resp_ready_i; flush_i aborts.
module rv32m_seq_ctrl
    import rv32m_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            mult_on_i,
    input  logic            div_on_i,
    input  logic            signed_A_i,
    input  logic            signed_B_i,
    input  logic            upper_rem_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [4:0]      rd_tag_i,
    input  logic            flush_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_tag_o,
    output logic            busy_o
);

    state_t            state_q;
    logic              kind_q;
    logic              sa_q;
    logic              sb_q;
    logic              up_q;
    logic [XLEN-1:0]   rs1_q;
    logic [XLEN-1:0]   rs2_q;
    logic [4:0]        tag_q;
    logic [CNT_W-1:0]  cnt_q;

    logic              legal;
    logic              req_kind;
    logic              a_neg;
    logic              b_neg;
    logic [XLEN-1:0]   a_mag;
    logic [XLEN-1:0]   b_mag;
    logic [XLEN-1:0]   core_op;
    logic [XLEN-1:0]   core_init;
    logic [XLEN-1:0]   core_hi;
    logic [XLEN-1:0]   core_lo;
    logic              div_zero;
    logic              div_ovf;
    logic              special;
    logic [2*XLEN-1:0] special_res;
    logic [2*XLEN-1:0] prod_mag;
    logic [XLEN-1:0]   q_fix;
    logic [XLEN-1:0]   r_fix;
    logic [2*XLEN-1:0] fix_res;
    logic              cache_hit;
    logic [XLEN-1:0]   cache_word;

    assign req_ready_o = (state_q == ST_IDLE);
    assign busy_o      = ~req_ready_o;

    // mult_on == div_on is not a real M-extension op and is dropped on accept
    assign legal    = mult_on_i ^ div_on_i;
    assign req_kind = div_on_i ? KIND_DIV : KIND_MUL;

    // Operand magnitudes; an operand is negative only when it is treated as signed
    assign a_neg = sa_q & rs1_q[XLEN-1];
    assign b_neg = sb_q & rs2_q[XLEN-1];
    assign a_mag = a_neg ? -rs1_q : rs1_q;
    assign b_mag = b_neg ? -rs2_q : rs2_q;

    // Multiply shifts the multiplier (b) out of lo; divide shifts the dividend (a) out of lo
    assign core_op   = (kind_q == KIND_DIV) ? b_mag : a_mag;
    assign core_init = (kind_q == KIND_DIV) ? a_mag : b_mag;

    // Cases resolved without iterating
    assign div_zero    = (rs2_q == '0);
    assign div_ovf     = sa_q && sb_q && (rs1_q == INT_MIN) && (rs2_q == '1);
    assign special     = (kind_q == KIND_DIV) && (div_zero || div_ovf);
    assign special_res = div_zero ? {rs1_q, DIV_BY_ZERO_Q} : {{XLEN{1'b0}}, INT_MIN};

    // Sign correction: product/quotient negative when signs differ, remainder follows the dividend
    assign prod_mag = {core_hi, core_lo};
    assign q_fix    = (a_neg ^ b_neg) ? -core_lo : core_lo;
    assign r_fix    = a_neg ? -core_hi : core_hi;
    assign fix_res  = (kind_q == KIND_MUL) ? ((a_neg ^ b_neg) ? -prod_mag : prod_mag)
                                           : {r_fix, q_fix};

    rv32m_iter_core u_core (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (state_q == ST_PREP),
        .step_i     (state_q == ST_CALC),
        .div_mode_i (kind_q),
        .op_i       (core_op),
        .init_i     (core_init),
        .hi_o       (core_hi),
        .lo_o       (core_lo)
    );

`ifdef RV32M_OP_CACHE_EN
    cache_ent_t cache_q;
    logic       cache_vld_q;
    logic       cache_wr;

    // A low-word multiply is sign-agnostic, so it may reuse any multiply entry with equal operands
    assign cache_hit = cache_vld_q && (cache_q.kind == req_kind)
                    && (cache_q.rs1 == rs1_i) && (cache_q.rs2 == rs2_i)
                    && (((cache_q.signed_a == signed_A_i) && (cache_q.signed_b == signed_B_i))
                        || ((req_kind == KIND_MUL) && !upper_rem_i));
    assign cache_word = sel_word(cache_q.data, upper_rem_i);
    assign cache_wr   = (state_q == ST_FIX) || ((state_q == ST_PREP) && special);

    // Capture every freshly computed result; any flush drops the entry
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cache_vld_q <= 1'b0;
            cache_q     <= '0;
        end else if (flush_i) begin
            cache_vld_q <= 1'b0;
        end else if (cache_wr) begin
            cache_vld_q <= 1'b1;
            cache_q     <= '{kind:     kind_q,
                             rs1:      rs1_q,
                             rs2:      rs2_q,
                             signed_a: sa_q,
                             signed_b: sb_q,
                             data:     (state_q == ST_FIX) ? fix_res : special_res};
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_word = '0;
`endif

    // Main sequencer: accept, prepare, iterate, correct, then hold the response until taken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            kind_q       <= KIND_MUL;
            sa_q         <= 1'b0;
            sb_q         <= 1'b0;
            up_q         <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            resp_valid_o <= 1'b0;
            result_o     <= '0;
            rd_tag_o     <= '0;
        end else if (flush_i) begin
            state_q      <= ST_IDLE;
            resp_valid_o <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i && legal) begin
                        kind_q <= req_kind;
                        sa_q   <= signed_A_i;
                        sb_q   <= signed_B_i;
                        up_q   <= upper_rem_i;
                        rs1_q  <= rs1_i;
                        rs2_q  <= rs2_i;
                        tag_q  <= rd_tag_i;
                        if (cache_hit) begin
                            result_o <= cache_word;
                            rd_tag_o <= rd_tag_i;
                            state_q  <= ST_DONE;
                        end else begin
                            state_q  <= ST_PREP;
                        end
                    end
                end
                ST_PREP: begin
                    cnt_q <= '0;
                    if (special) begin
                        result_o <= sel_word(special_res, up_q);
                        rd_tag_o <= tag_q;
                        state_q  <= ST_DONE;
                    end else begin
                        state_q  <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(STEPS - 1)) begin
                        state_q <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    result_o <= sel_word(fix_res, up_q);
                    rd_tag_o <= tag_q;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    if (!resp_valid_o) begin
                        resp_valid_o <= 1'b1;
                    end else if (resp_ready_i) begin
                        resp_valid_o <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
